// File: rtl/uart_tx_buffered_if.sv
// Byte handshake between the host-link controller (master) and the buffered UART transmitter (slave).
interface uart_tx_buffered_if;
  logic       TX_enable;
  logic [7:0] TX_data;
  logic       tx_ready;
  logic       busy;
  logic       byte_done;

  modport master (
    output TX_enable,
    output TX_data,
    input  tx_ready,
    input  busy,
    input  byte_done
  );

  modport slave (
    input  TX_enable,
    input  TX_data,
    output tx_ready,
    output busy,
    output byte_done
  );
endinterface

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter with a one-byte holding register for gapless back-to-back frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_buffered #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_buffered_if.slave bus,
  output logic              tx
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        hold_q, hold_d;
  logic              hold_valid_q, hold_valid_d;
  logic              tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic bit_end;
  logic stop_end;
  logic load_direct;
  logic load_hold;

  assign bit_end  = (baud_q == BAUD_LAST);
  assign stop_end = (state_q == STOP) && bit_end;

  // A byte skips the holding register whenever the shifter is free on this edge.
  assign load_direct = bus.TX_enable && ((state_q == IDLE) || (stop_end && !hold_valid_q));
  assign load_hold   = bus.TX_enable && !load_direct && (!hold_valid_q || stop_end);

  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
`ifdef UART_TX_PARITY_EN
    parity_d     = parity_q;
`endif

    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (hold_valid_q) begin
            state_d      = START;
            shift_d      = hold_q;
            hold_valid_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d     = ^hold_q;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: ;
    endcase

    if (load_direct) begin
      state_d = START;
      shift_d = bus.TX_data;
      baud_d  = '0;
`ifdef UART_TX_PARITY_EN
      parity_d = ^bus.TX_data;
`endif
    end else if (load_hold) begin
      hold_d       = bus.TX_data;
      hold_valid_d = 1'b1;
    end

    // tx is registered, so it is derived from where the shifter will be after this edge.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      baud_q       <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'd0;
      hold_q       <= 8'd0;
      hold_valid_q <= 1'b0;
      tx_q         <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      tx_q         <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign tx            = tx_q;
  assign bus.tx_ready  = !hold_valid_q;
  assign bus.busy      = (state_q != IDLE) || hold_valid_q;
  assign bus.byte_done = stop_end;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered (CLKS_PER_BIT = 10); follows UART_TX_PARITY_EN when defined.
module tb_uart_tx_buffered;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYCLES = FRAME_BITS * CPB;

  // line_bits lists the data bits in the order they appear on the wire, first bit in [7].
  typedef struct {
    logic [7:0] data;
    logic [7:0] line_bits;
    logic       parity_bit;
    string      name;
  } frame_vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic tx;

  uart_tx_buffered_if bus ();

  uart_tx_buffered #(
    .CLK_FREQ (1000000),
    .BAUD_RATE(100000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .tx   (tx)
  );

  always #5 clk = ~clk;

  int         compared   = 0;
  int         mismatched = 0;
  int         done_count = 0;
  bit         reset_seen = 1'b0;
  logic [7:0] sb_queue[$];
  frame_vec_t vectors[5];

  always @(negedge clk) if (bus.byte_done === 1'b1) done_count++;
  always @(negedge rst_n) reset_seen = 1'b1;

  task automatic checkOutput(input string what, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", what, $time, actual, expected);
    end
  endtask

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input bit expect_sent);
    bus.TX_enable = 1'b1;
    bus.TX_data   = data;
    if (expect_sent) sb_queue.push_back(data);
    step_cycle();
    bus.TX_enable = 1'b0;
    bus.TX_data   = 8'($urandom);
  endtask

  function automatic logic exp_bit(input logic [7:0] line_bits, input logic parity_bit, input int bit_idx);
    if (bit_idx == 0) return 1'b0;
    if (bit_idx <= 8) return line_bits[8 - bit_idx];
    if (bit_idx == 9 && FRAME_BITS == 11) return parity_bit;
    return 1'b1;
  endfunction

  // Called in cycle 0 of a frame; checks every bit boundary and the byte_done position.
  task automatic check_frame(input string what, input logic [7:0] line_bits, input logic parity_bit);
    for (int c = 0; c < FRAME_CYCLES; c++) begin
      if ((c % CPB == 0) || (c % CPB == CPB - 1))
        checkOutput({what, "_tx"}, tx, exp_bit(line_bits, parity_bit, c / CPB));
      checkOutput({what, "_byte_done"}, bus.byte_done, (c == FRAME_CYCLES - 1));
      step_cycle();
    end
    checkOutput({what, "_busy_after"}, bus.busy, 0);
    checkOutput({what, "_tx_after"}, tx, 1);
    checkOutput({what, "_ready_after"}, bus.tx_ready, 1);
  endtask

  // Line receiver: decodes each frame mid-bit and compares it with the scoreboard.
  initial begin : monitor
    logic [7:0] rx;
    logic       start_bit;
    logic       stop_bit;
    logic       par_bit;
    wait (rst_n === 1'b1);
    forever begin
      @(negedge tx);
      reset_seen = 1'b0;
      repeat (CPB / 2) @(posedge clk);
      #1;
      start_bit = tx;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(posedge clk);
        #1;
        rx[i] = tx;
      end
      par_bit = ^rx;
`ifdef UART_TX_PARITY_EN
      repeat (CPB) @(posedge clk);
      #1;
      par_bit = tx;
`endif
      repeat (CPB) @(posedge clk);
      #1;
      stop_bit = tx;
      if (!reset_seen) begin
        checkOutput("mon_start_bit", start_bit, 0);
        checkOutput("mon_stop_bit", stop_bit, 1);
        checkOutput("mon_parity", par_bit, ^rx);
        if (sb_queue.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL sb_unexpected_frame at %0t: got %0h, expected no frame", $time, rx);
        end else begin
          checkOutput("sb_byte", rx, sb_queue.pop_front());
        end
      end
    end
  end

  initial begin
    int d0;
    vectors[0] = '{data: 8'h55, line_bits: 8'b10101010, parity_bit: 1'b0, name: "v55"};
    vectors[1] = '{data: 8'h00, line_bits: 8'b00000000, parity_bit: 1'b0, name: "v00"};
    vectors[2] = '{data: 8'hFF, line_bits: 8'b11111111, parity_bit: 1'b0, name: "vFF"};
    vectors[3] = '{data: 8'h80, line_bits: 8'b00000001, parity_bit: 1'b1, name: "v80"};
    vectors[4] = '{data: 8'h07, line_bits: 8'b11100000, parity_bit: 1'b1, name: "v07"};

    rst_n         = 1'b0;
    bus.TX_enable = 1'b0;
    bus.TX_data   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_tx", tx, 1);
    checkOutput("reset_tx_ready", bus.tx_ready, 1);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_byte_done", bus.byte_done, 0);
    rst_n = 1'b1;
    step_cycle();
    step_cycle();

    $display("[TB] single-frame vectors");
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vectors[v].data, 1'b1);
      check_frame(vectors[v].name, vectors[v].line_bits, vectors[v].parity_bit);
      step_cycle();
    end

    $display("[TB] back-to-back frames");
    applyStimulus(8'hA5, 1'b1);
    for (int c = 0; c < 2 * FRAME_CYCLES + 10; c++) begin
      checkOutput("b2b_tx_ready", bus.tx_ready, (c >= 5 && c < FRAME_CYCLES) ? 0 : 1);
      checkOutput("b2b_byte_done", bus.byte_done, (c == FRAME_CYCLES - 1 || c == 2 * FRAME_CYCLES - 1) ? 1 : 0);
      if (c >= FRAME_CYCLES && c < FRAME_CYCLES + CPB) checkOutput("b2b_start2", tx, 0);
      if (c == 4) begin
        bus.TX_enable = 1'b1;
        bus.TX_data   = 8'h3C;
        sb_queue.push_back(8'h3C);
      end else if (c == 5) begin
        bus.TX_enable = 1'b0;
        bus.TX_data   = 8'h00;
      end
      step_cycle();
    end
    checkOutput("b2b_busy_after", bus.busy, 0);

    $display("[TB] overflow while hold is full");
    d0 = done_count;
    applyStimulus(8'h11, 1'b1);
    repeat (4) step_cycle();
    applyStimulus(8'h22, 1'b1);
    checkOutput("ovf_ready_low", bus.tx_ready, 0);
    repeat (14) step_cycle();
    applyStimulus(8'h33, 1'b0);
    checkOutput("ovf_ready_still_low", bus.tx_ready, 0);
    repeat (2 * FRAME_CYCLES) step_cycle();
    checkOutput("ovf_done_count", done_count - d0, 2);
    checkOutput("ovf_busy_after", bus.busy, 0);

    $display("[TB] reset mid-frame");
    d0 = done_count;
    applyStimulus(8'hF0, 1'b0);
    repeat (9) step_cycle();
    applyStimulus(8'h99, 1'b0);
    repeat (34) step_cycle();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_tx_async", tx, 1);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_tx_ready", bus.tx_ready, 1);
    checkOutput("rst_byte_done", bus.byte_done, 0);
    repeat (5) step_cycle();
    checkOutput("rst_tx_held", tx, 1);
    rst_n = 1'b1;
    repeat (FRAME_CYCLES) step_cycle();
    checkOutput("rst_no_done", done_count - d0, 0);
    checkOutput("rst_idle_tx", tx, 1);
    applyStimulus(8'h0F, 1'b1);
    check_frame("after_rst", 8'b11110000, 1'b0);

    $display("[TB] idle line");
    d0 = done_count;
    for (int c = 0; c < 1000; c++) begin
      bus.TX_data = 8'($urandom);
      if (c % 10 == 0) begin
        checkOutput("idle_tx", tx, 1);
        checkOutput("idle_tx_ready", bus.tx_ready, 1);
      end
      step_cycle();
    end
    checkOutput("idle_no_done", done_count - d0, 0);
    checkOutput("sb_pending", sb_queue.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
